// File: rtl/banded_sw_pe_array.sv
// banded_sw_pe_array: linear systolic Smith-Waterman band of B PEs with running best-score tracking.
// Optional `SW_SCORE_DEBUG_EN exposes every registered H_k on dbg_scores.
module banded_sw_pe_array #(
  parameter int B = 4,
  parameter int WIN = 12,
  parameter int SCORE_W = 8,
  parameter int MATCH = 2,
  parameter int MISMATCH = 1,
  parameter int GAP = 1,
  localparam int PW = (B > 1) ? $clog2(B) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           ctr,
  input  logic [3*B-1:0]       R,
  input  logic [3*B-1:0]       Q,
  output logic [3*B-1:0]       out_pe,
  output logic [SCORE_W-1:0]   max_score,
  output logic [PW-1:0]        max_pe,
  output logic [7:0]           max_ctr
`ifdef SW_SCORE_DEBUG_EN
  ,
  output logic [B*SCORE_W-1:0] dbg_scores
`endif
);
  localparam int SW = SCORE_W + 2;
  localparam logic signed [SW-1:0] SM = SW'(MATCH);
  localparam logic signed [SW-1:0] SX = SW'(MISMATCH);
  localparam logic signed [SW-1:0] SG = SW'(GAP);
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** SCORE_W) - 1);
  logic [B*SCORE_W-1:0] h_vec, hn_vec;
  logic [(B+2)*SCORE_W-1:0] hz;
  logic [3*B-1:0] pn_vec;
  logic [SCORE_W-1:0] bs;
  logic [PW-1:0] bk;
  logic upd;
  // zero-padded on both ends so edge PEs see 0 for their missing neighbour
  assign hz = {{SCORE_W{1'b0}}, h_vec, {SCORE_W{1'b0}}};
  for (genvar k = 0; k < B; k++) begin : g_pe
    logic [2:0] r_s, q_s;
    logic signed [SW-1:0] hd, hu, hl, d, u, l, du, best;
    logic valid, match;
    assign r_s = R[3*k +: 3];
    assign q_s = Q[3*(B-1-k) +: 3];
    assign valid = (int'(ctr) >= k) && (int'(ctr) <= k + WIN - 1) && (r_s != 3'd0) && (q_s != 3'd0);
    assign match = (r_s == q_s) && (r_s <= 3'd4);
    assign hu = $signed({2'b00, hz[k*SCORE_W +: SCORE_W]});
    assign hd = $signed({2'b00, hz[(k+1)*SCORE_W +: SCORE_W]});
    assign hl = $signed({2'b00, hz[(k+2)*SCORE_W +: SCORE_W]});
    assign d = hd + (match ? SM : -SX);
    assign u = hu - SG;
    assign l = hl - SG;
    assign du = (d >= u) ? d : u;
    assign best = (du >= l) ? du : l;
    assign hn_vec[k*SCORE_W +: SCORE_W] = (!valid || best <= 0) ? '0 :
                                          (best > MAXV) ? MAXV[SCORE_W-1:0] : best[SCORE_W-1:0];
    assign pn_vec[3*k +: 3] = (!valid || best <= 0) ? 3'd0 : (d == best) ? 3'd1 : (u == best) ? 3'd2 : 3'd3;
  end
  // strict > keeps the lowest k among equal winners
  always_comb begin
    bs = max_score;
    bk = max_pe;
    upd = 1'b0;
    for (int k = 0; k < B; k++)
      if (hn_vec[k*SCORE_W +: SCORE_W] > bs) begin
        bs = hn_vec[k*SCORE_W +: SCORE_W];
        bk = PW'(k);
        upd = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || ctr[7]) begin
      h_vec <= '0;
      out_pe <= '0;
      max_score <= '0;
      max_pe <= '0;
      max_ctr <= '0;
    end else begin
      h_vec <= hn_vec;
      out_pe <= pn_vec;
      if (upd) begin
        max_score <= bs;
        max_pe <= bk;
        max_ctr <= ctr;
      end
    end
`ifdef SW_SCORE_DEBUG_EN
  assign dbg_scores = h_vec;
`endif
endmodule

// File: tb/tb_banded_sw_pe_array.sv
// tb_banded_sw_pe_array: drives 8-bit and 4-bit score builds in lockstep against an integer band model.
module tb_banded_sw_pe_array;
  localparam int B = 4;
  localparam int WIN = 12;
  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] ctr;
  logic [11:0] R, Q;
  logic [11:0] op8, op4;
  logic [7:0] ms8, mc8, mc4;
  logic [3:0] ms4;
  logic [1:0] mp8, mp4;
  int checks = 0, errors = 0;
  int mh[2][B];
  int mx[2], mpk[2], mc[2];
  logic [11:0] mpv[2];
  int cap[2] = '{255, 15};
`ifdef SW_SCORE_DEBUG_EN
  logic [31:0] dbg8;
  logic [15:0] dbg4;
`endif
  always #5 clk = ~clk;
  banded_sw_pe_array u8 (
    .clk(clk), .reset_n(reset_n), .ctr(ctr), .R(R), .Q(Q),
    .out_pe(op8), .max_score(ms8), .max_pe(mp8), .max_ctr(mc8)
`ifdef SW_SCORE_DEBUG_EN
    , .dbg_scores(dbg8)
`endif
  );
  banded_sw_pe_array #(.SCORE_W(4)) u4 (
    .clk(clk), .reset_n(reset_n), .ctr(ctr), .R(R), .Q(Q),
    .out_pe(op4), .max_score(ms4), .max_pe(mp4), .max_ctr(mc4)
`ifdef SW_SCORE_DEBUG_EN
    , .dbg_scores(dbg4)
`endif
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < B; k++) mh[s][k] = 0;
      mx[s] = 0; mpk[s] = 0; mc[s] = 0; mpv[s] = '0;
    end
  endtask
  task automatic model_step(input logic [7:0] c, input logic [11:0] r, input logic [11:0] q);
    if (c >= 8'd128) begin
      model_clear();
      return;
    end
    for (int s = 0; s < 2; s++) begin
      int nh[B];
      for (int k = 0; k < B; k++) begin
        logic [2:0] rs, qs;
        int d, u, l, best, ptr;
        bit valid;
        rs = r[3*k +: 3];
        qs = q[3*(B-1-k) +: 3];
        valid = (int'(c) >= k) && (int'(c) <= k + WIN - 1) && rs != 0 && qs != 0;
        d = mh[s][k] + ((rs == qs && rs <= 4) ? 2 : -1);
        u = ((k > 0) ? mh[s][k-1] : 0) - 1;
        l = ((k < B - 1) ? mh[s][k+1] : 0) - 1;
        best = max2(0, max2(d, max2(u, l)));
        ptr = (!valid || best == 0) ? 0 : (d == best) ? 1 : (u == best) ? 2 : 3;
        nh[k] = valid ? ((best > cap[s]) ? cap[s] : best) : 0;
        mpv[s][3*k +: 3] = 3'(ptr);
      end
      for (int k = 0; k < B; k++) begin
        mh[s][k] = nh[k];
        if (nh[k] > mx[s]) begin mx[s] = nh[k]; mpk[s] = k; mc[s] = int'(c); end
      end
    end
  endtask
  task automatic compare_all();
    for (int s = 0; s < 2; s++) begin
      check(s ? "out_pe4" : "out_pe8", s ? int'(op4) : int'(op8), int'(mpv[s]));
      check(s ? "max_score4" : "max_score8", s ? int'(ms4) : int'(ms8), mx[s]);
      check(s ? "max_pe4" : "max_pe8", s ? int'(mp4) : int'(mp8), mpk[s]);
      check(s ? "max_ctr4" : "max_ctr8", s ? int'(mc4) : int'(mc8), mc[s]);
`ifdef SW_SCORE_DEBUG_EN
      for (int k = 0; k < B; k++)
        check(s ? "dbg4" : "dbg8", s ? int'(dbg4[4*k +: 4]) : int'(dbg8[8*k +: 8]), mh[s][k]);
`endif
    end
  endtask
  task automatic step(input logic [7:0] c, input logic [11:0] r, input logic [11:0] q);
    ctr = c; R = r; Q = q;
    model_step(c, r, q);
    @(posedge clk);
    #1;
    compare_all();
  endtask
  function automatic logic [2:0] rsym();
    int v;
    v = $urandom_range(0, 15);
    return (v == 0) ? 3'd0 : (v >= 13) ? 3'(v - 8) : 3'(1 + (v - 1) % 4);
  endfunction
  initial begin
    int sat[10] = '{2, 4, 6, 8, 10, 12, 14, 15, 15, 15};
    reset_n = 1'b0; ctr = 8'hFF; R = '0; Q = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    compare_all();
    step(8'hFE, '0, '0);
    step(8'd0, 12'h001, 12'h200);
    check("single_ptr", int'(op8), 12'h001);
    check("single_max", int'(ms8), 2);
    step(8'hFE, '0, '0);
    step(8'd0, 12'h001, 12'h400);
    check("mismatch_ptr", int'(op8[2:0]), 0);
    check("mismatch_max", int'(ms8), 0);
    step(8'hFE, '0, '0);
    step(8'd2, 12'h200, 12'h001);
    check("win_before", int'(op8[11:9]), 0);
    step(8'hFE, '0, '0);
    step(8'd3, 12'h200, 12'h001);
    check("win_in", int'(op8[11:9]), 1);
    step(8'hFE, '0, '0);
    step(8'd15, 12'h200, 12'h001);
    check("win_after", int'(op8[11:9]), 0);
    step(8'hFE, '0, '0);
    step(8'd0, 12'h000, 12'h200);
    check("pad", int'(op8[2:0]), 0);
    step(8'hFE, '0, '0);
    for (int c = 0; c < 10; c++) begin
      step(8'(c), 12'h001, 12'h200);
      check("sat_score", int'(ms4), sat[c]);
      check("sat_ptr", int'(op4[2:0]), 1);
    end
    step(8'hFE, '0, '0);
    for (int c = 0; c < 3; c++) step(8'(c), 12'h001, 12'h200);
    check("pre_clear_max", int'(ms8), 6);
    step(8'hFE, '0, '0);
    check("clear_max", int'(ms8), 0);
    check("clear_ptr", int'(op8), 0);
    for (int c = 0; c < 3; c++) step(8'(c), 12'h249, 12'h249);
    ctr = 8'd3; R = 12'h249; Q = 12'h249;
    #1 reset_n = 1'b0;
    #1;
    model_clear();
    compare_all();
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int a = 0; a < 40; a++) begin
      bit bias;
      bias = 1'($urandom_range(0, 1));
      step(8'($urandom_range(128, 255)), 12'($urandom), 12'($urandom));
      for (int c = 0; c < 16; c++) begin
        logic [11:0] r, q;
        for (int k = 0; k < B; k++) begin
          logic [2:0] rs;
          rs = rsym();
          r[3*k +: 3] = rs;
          q[3*(B-1-k) +: 3] = (bias && $urandom_range(0, 4) != 0) ? rs : rsym();
        end
        step(8'(c), r, q);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
